// File: rtl/cmd_frame_sched_pkg.sv
// Shared definitions for the command-frame path: scheduler state encoding,
// frame geometry and the header bytes used by the parser and the TX side.
package cmd_frame_sched_pkg;

  localparam int FRAME_BYTES = 12;
  localparam int HDR_BYTES   = 2;
  localparam int CMD_BYTES   = 9;
  localparam int CSUM_BYTES  = 1;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hAA;

  // Encoding is visible on state_o (LED/debug), so values are fixed.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_WAIT_FD  = 4'd2,
    ST_APPLY    = 4'd3,
    ST_WAIT_CFG = 4'd4,
    ST_DONE     = 4'd5,
    ST_RECOVER  = 4'd6,
    ST_HOLD     = 4'd7
  } state_t;

endpackage

// File: rtl/cmd_frame_sched.sv
// Command-frame scheduler: starts the parser once a whole frame is buffered,
// hands the parsed config to the configurator and recovers a stuck parser.
module cmd_frame_sched
  import cmd_frame_sched_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_BYTES,
  parameter int CW        = 10,
  parameter int FD_TMO    = 256,
  parameter int CFG_TMO   = 65535,
  parameter int RST_CYC   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] fifoc_level,
  output logic          fs,
  input  logic          fd,
  output logic          parser_rst,
  output logic          fifoc_flush,
  output logic          cfg_start,
  input  logic          cfg_done,
  output logic          cmd_ok,
  output logic          busy,
  output logic [7:0]    err_cnt,
  output logic [3:0]    state_o
);

  localparam int TMR_MAX = (FD_TMO > CFG_TMO) ? FD_TMO : CFG_TMO;
  localparam int TW      = $clog2(TMR_MAX + 1);

  localparam logic [CW-1:0] LVL_START = CW'(FRAME_LEN);
  localparam logic [TW-1:0] FD_LAST   = TW'(FD_TMO - 1);
  localparam logic [TW-1:0] CFG_LAST  = TW'(CFG_TMO - 1);
  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYC - 1);

  state_t          state;
  state_t          state_n;
  logic [TW-1:0]   timer;
  logic            enter_recover;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:     if (fifoc_level >= LVL_START) state_n = ST_START;
      ST_START:    state_n = ST_WAIT_FD;
      ST_WAIT_FD: begin
        if (fd)                     state_n = ST_APPLY;
        else if (timer == FD_LAST)  state_n = ST_RECOVER;
      end
      ST_APPLY:    state_n = ST_WAIT_CFG;
      ST_WAIT_CFG: begin
        if (cfg_done)               state_n = ST_DONE;
        else if (timer == CFG_LAST) state_n = ST_RECOVER;
      end
      // Parser must leave LAST (fd low) before another frame can start.
      ST_DONE: begin
        if (!fd)                    state_n = ST_IDLE;
        else if (timer == FD_LAST)  state_n = ST_RECOVER;
      end
      ST_RECOVER:  if (timer == RST_LAST) state_n = ST_HOLD;
      ST_HOLD:     state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  assign enter_recover = (state_n == ST_RECOVER) && (state != ST_RECOVER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)
        timer <= '0;
      else if (state != ST_IDLE)
        timer <= timer + 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with state_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs          <= 1'b0;
      parser_rst  <= 1'b0;
      fifoc_flush <= 1'b0;
      cfg_start   <= 1'b0;
      cmd_ok      <= 1'b0;
      busy        <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      fs          <= (state_n == ST_WAIT_FD) || (state_n == ST_APPLY) ||
                     (state_n == ST_WAIT_CFG);
      parser_rst  <= (state_n == ST_RECOVER);
      fifoc_flush <= enter_recover;
      cfg_start   <= (state_n == ST_APPLY);
      cmd_ok      <= (state_n == ST_DONE) && (state != ST_DONE);
      busy        <= (state_n != ST_IDLE);
      if (enter_recover)
        err_cnt <= sat_inc8(err_cnt);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_cmd_frame_sched.sv
// Randomized bench for cmd_frame_sched: each frame is described by its event
// delays and the expected state/output timeline is derived from them.
module tb_cmd_frame_sched;

  localparam int FRAME_LEN = 12;
  localparam int CW        = 10;
  localparam int FD_TMO    = 32;
  localparam int CFG_TMO   = 64;
  localparam int RST_CYC   = 4;
  localparam int NEVER     = 100000;

  logic          clk;
  logic          rst;
  logic [CW-1:0] fifoc_level;
  logic          fs;
  logic          fd;
  logic          parser_rst;
  logic          fifoc_flush;
  logic          cfg_start;
  logic          cfg_done;
  logic          cmd_ok;
  logic          busy;
  logic [7:0]    err_cnt;
  logic [3:0]    state_o;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_err = 0;

  cmd_frame_sched #(
    .FRAME_LEN(FRAME_LEN), .CW(CW), .FD_TMO(FD_TMO),
    .CFG_TMO(CFG_TMO), .RST_CYC(RST_CYC)
  ) dut (
    .clk(clk), .rst(rst), .fifoc_level(fifoc_level), .fs(fs), .fd(fd),
    .parser_rst(parser_rst), .fifoc_flush(fifoc_flush), .cfg_start(cfg_start),
    .cfg_done(cfg_done), .cmd_ok(cmd_ok), .busy(busy), .err_cnt(err_cnt),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Expected control word {fs, parser_rst, fifoc_flush, cfg_start, cmd_ok, busy}.
  task automatic expect_cycle(input int st_e, input bit cs_e, input bit ok_e, input bit fl_e);
    bit fs_e;
    bit prst_e;
    bit busy_e;
    fs_e   = (st_e >= 2) && (st_e <= 4);
    prst_e = (st_e == 6);
    busy_e = (st_e != 0);
    check_val("state_o", {28'b0, state_o}, st_e);
    check_val("ctl", {26'b0, fs, parser_rst, fifoc_flush, cfg_start, cmd_ok, busy},
              {26'b0, fs_e, prst_e, fl_e, cs_e, ok_e, busy_e});
    check_val("err_cnt", {24'b0, err_cnt}, exp_err);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // fd_delay: WAIT_FD cycles before fd is seen (NEVER = parser hangs).
  // cfg_delay: WAIT_CFG cycles before cfg_done pulses (NEVER = no answer).
  // fd_hold: DONE cycles fd stays high. abort_t > 0: async reset after that cycle.
  task automatic do_frame(input int n_idle, input int fd_delay, input int cfg_delay,
                          input int fd_hold, input int abort_t);
    int st[256];
    int e_app, e_cfg, e_done, e_r, t_end, fd_end, noise_end, last;
    bit fd_ok;
    for (int i = 0; i < 256; i++) st[i] = 0;
    e_app = -1; e_cfg = -1; e_done = -1; e_r = -1; t_end = 0; fd_end = -1;
    fd_ok = (fd_delay <= FD_TMO - 1);
    st[1] = 1;
    if (!fd_ok) begin
      e_r = 2 + FD_TMO;
      for (int t = 2; t < e_r; t++) st[t] = 2;
    end else begin
      e_app = 3 + fd_delay;
      for (int t = 2; t < e_app; t++) st[t] = 2;
      st[e_app] = 3;
      e_cfg = e_app + 1;
      if (cfg_delay > CFG_TMO - 1) begin
        e_r = e_cfg + CFG_TMO;
        for (int t = e_cfg; t < e_r; t++) st[t] = 4;
        fd_end = e_r;
      end else begin
        e_done = e_cfg + cfg_delay + 1;
        for (int t = e_cfg; t < e_done; t++) st[t] = 4;
        if (fd_hold <= FD_TMO - 1) begin
          t_end = e_done + fd_hold + 1;
          for (int t = e_done; t < t_end; t++) st[t] = 5;
          fd_end = e_done + fd_hold;
        end else begin
          e_r = e_done + FD_TMO;
          for (int t = e_done; t < e_r; t++) st[t] = 5;
          fd_end = e_r;
        end
      end
    end
    if (e_r > 0) begin
      for (int t = e_r; t < e_r + RST_CYC; t++) st[t] = 6;
      st[e_r + RST_CYC] = 7;
      t_end = e_r + RST_CYC + 1;
    end
    noise_end = fd_ok ? e_cfg : t_end;

    // Idle: level below threshold, fd and cfg_done noise must be ignored.
    for (int i = 0; i < n_idle; i++) begin
      fifoc_level = (i == 0) ? CW'(FRAME_LEN - 1) : CW'($urandom_range(0, FRAME_LEN - 1));
      fd          = 1'($urandom);
      cfg_done    = 1'($urandom);
      step();
      expect_cycle(0, 0, 0, 0);
    end

    last = (abort_t > 0) ? abort_t : t_end;
    for (int t = 1; t <= last; t++) begin
      fifoc_level = (t == 1) ? CW'($urandom_range(FRAME_LEN, 1023))
                             : CW'($urandom_range(0, FRAME_LEN - 1));
      fd       = fd_ok && (t >= 3 + fd_delay) && (t <= fd_end);
      cfg_done = (t == e_done) || ((t <= noise_end) && ($urandom_range(0, 3) == 0));
      step();
      if (t == e_r) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      expect_cycle(st[t], t == e_app, t == e_done, t == e_r);
    end
    fd       = 1'b0;
    cfg_done = 1'b0;

    if (abort_t > 0) begin
      #2 rst = 1'b1;
      #1;
      exp_err = 0;
      expect_cycle(0, 0, 0, 0);
      step();
      #2 rst = 1'b0;
      step();
      expect_cycle(0, 0, 0, 0);
    end
  endtask

  initial begin
    int fdl, cfl, fh;
    rst         = 1'b1;
    fifoc_level = '0;
    fd          = 1'b0;
    cfg_done    = 1'b0;
    step();
    step();
    expect_cycle(0, 0, 0, 0);
    #2 rst = 1'b0;
    step();
    expect_cycle(0, 0, 0, 0);

    // Good frame, fd hang, configurator hang, tie-breaks, DONE fd hang.
    do_frame(5, 15, 2, 2, 0);
    do_frame(2, NEVER, 0, 0, 0);
    do_frame(2, 4, NEVER, 0, 0);
    do_frame(1, FD_TMO - 1, CFG_TMO - 1, 0, 0);
    do_frame(1, 0, 0, FD_TMO - 1, 0);
    do_frame(1, 3, 1, FD_TMO, 0);

    for (int n = 0; n < 40; n++) begin
      fdl = ($urandom_range(0, 4) == 0) ? NEVER : $urandom_range(0, FD_TMO - 1);
      cfl = ($urandom_range(0, 4) == 0) ? NEVER : $urandom_range(0, CFG_TMO - 1);
      fh  = ($urandom_range(0, 5) == 0) ? FD_TMO + $urandom_range(0, 2)
                                        : $urandom_range(0, 4);
      do_frame($urandom_range(1, 4), fdl, cfl, fh, 0);
    end

    // Reset in the middle of WAIT_CFG, then a clean frame.
    do_frame(2, 3, NEVER, 0, 12);
    do_frame(3, 5, 3, 1, 0);

    for (int n = 0; n < 260; n++) do_frame(1, NEVER, 0, 0, 0);
    check_val("err_sat", {24'b0, err_cnt}, 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
